// File: rtl/display_pkg.sv
// display_pkg: framebuffer geometry and loader state encoding shared by the display controller
package display_pkg;
    localparam int WIDTH       = 32;
    localparam int HEIGHT      = 16;
    localparam int BPP         = 3;
    localparam int FRAME_BYTES = WIDTH * HEIGHT * BPP;
    localparam int ADDR_W      = $clog2(FRAME_BYTES);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_FLIP = 2'd2
    } state_t;
endpackage

// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl: owns the displayed bank, swapping it on a vblank once a frame is ready
module frame_bank_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_ready,
    input  logic       i_vblank,
    output logic       o_done,
    output logic       o_front_bank,
    output logic       o_flip,
    output logic [7:0] o_frame_count
);
    // Combinational ack so the requester leaves its wait state on the same edge as the swap
    assign o_done = i_frame_ready & i_vblank;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_front_bank  <= 1'b0;
            o_flip        <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_flip <= o_done;
            if (o_done) begin
                o_front_bank  <= ~o_front_bank;
                o_frame_count <= o_frame_count + 8'd1;
            end
        end
    end
endmodule

// File: rtl/spi_frame_loader.sv
// spi_frame_loader: sequences the SPI slave byte stream into the back bank of a double-buffered framebuffer
module spi_frame_loader
    import display_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_rx_sot,
    input  logic              i_rx_eot,
    input  logic              i_vblank,
    output logic              o_wr_en,
    output logic              o_wr_bank,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_front_bank,
    output logic              o_flip,
    output logic              o_err_short,
    output logic              o_err_long,
    output logic [7:0]        o_frame_count
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(FRAME_BYTES);

    state_t          r_state;
    logic [ADDR_W:0] r_cnt;
    logic            r_eot;
    logic            r_drop;
    logic            w_eot_rise;
    logic            w_full;
    logic            w_done;

    assign w_eot_rise = i_rx_eot & ~r_eot;
    assign w_full     = r_cnt == FULL;
    assign o_wr_bank  = ~o_front_bank;

    frame_bank_ctrl u_bank (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_ready (r_state == WAIT_FLIP),
        .i_vblank      (i_vblank),
        .o_done        (w_done),
        .o_front_bank  (o_front_bank),
        .o_flip        (o_flip),
        .o_frame_count (o_frame_count)
    );

    // r_eot resets high so an idle-high SS after reset is not seen as an end of transfer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_eot       <= 1'b1;
            r_drop      <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_err_short <= 1'b0;
            o_err_long  <= 1'b0;
        end else begin
            r_eot       <= i_rx_eot;
            o_wr_en     <= 1'b0;
            o_err_short <= 1'b0;
            o_err_long  <= 1'b0;
            case (r_state)
                IDLE: if (i_rx_valid && i_rx_sot && !w_eot_rise) begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= '0;
                    o_wr_data <= i_rx_data;
                    r_cnt     <= (ADDR_W + 1)'(1);
                    r_drop    <= 1'b0;
                    r_state   <= LOAD;
                end
                LOAD: if (w_eot_rise) begin
                    r_state     <= w_full ? WAIT_FLIP : IDLE;
                    o_err_short <= ~w_full;
                end else if (i_rx_valid && (i_rx_sot || !w_full)) begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= i_rx_sot ? '0 : r_cnt[ADDR_W-1:0];
                    o_wr_data <= i_rx_data;
                    r_cnt     <= i_rx_sot ? (ADDR_W + 1)'(1) : r_cnt + 1'b1;
                    r_drop    <= i_rx_sot ? 1'b0 : r_drop;
                end else if (i_rx_valid && !r_drop) begin
                    o_err_long <= 1'b1;
                    r_drop     <= 1'b1;
                end
                WAIT_FLIP: if (w_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_loader.sv
// tb_spi_frame_loader: scoreboard bench driving directed SPI frames into spi_frame_loader
module tb_spi_frame_loader;
    import display_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid, rx_sot, rx_eot, vblank;
    logic              wr_en, wr_bank, front_bank, flip, err_short, err_long;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data, frame_count;

    int tests = 0;
    int fails = 0;

    typedef struct {int k; int a; int b;} ev_t;
    ev_t q[$];

    spi_frame_loader dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .i_rx_sot      (rx_sot),
        .i_rx_eot      (rx_eot),
        .i_vblank      (vblank),
        .o_wr_en       (wr_en),
        .o_wr_bank     (wr_bank),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_front_bank  (front_bank),
        .o_flip        (flip),
        .o_err_short   (err_short),
        .o_err_long    (err_long),
        .o_frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // kinds: 0 write (a=addr, b={bank,data}), 1 err_short, 2 err_long, 3 flip (a=front, b=count)
    function automatic void push(int k, int a, int b);
        ev_t e;
        e.k = k;
        e.a = a;
        e.b = b;
        q.push_back(e);
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(int k, int a, int b, string name);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected: got a=%0d b=%0h, nothing expected", name, a, b);
        end else begin
            e = q.pop_front();
            if (e.k != k || e.a != a || e.b != b) begin
                fails++;
                $display("FAIL %s: got kind=%0d a=%0d b=%0h expected kind=%0d a=%0d b=%0h", name, k, a, b, e.k, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (wr_en)     expect_ev(0, int'(wr_addr), int'({wr_bank, wr_data}), "write");
        if (err_short) expect_ev(1, 0, 0, "err_short");
        if (err_long)  expect_ev(2, 0, 0, "err_long");
        if (flip)      expect_ev(3, int'(front_bank), int'(frame_count), "flip");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        chk(name, q.size(), 0);
    endtask

    task automatic frame_body(int n, int bank);
        logic [7:0] d;
        rx_eot = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? 8'h11 : 8'(i);
            if (i < FRAME_BYTES) push(0, i, (bank << 8) | int'(d));
            else if (i == FRAME_BYTES) push(2, 0, 0);
            rx_valid = 1'b1;
            rx_sot   = (i == 0);
            rx_data  = d;
            tick();
            rx_valid = 1'b0;
            rx_sot   = 1'b0;
            tick();
        end
    endtask

    task automatic end_frame(bit short_frame);
        if (short_frame) push(1, 0, 0);
        rx_eot = 1'b1;
        tick();
        tick();
    endtask

    task automatic do_flip(int nf, int nc, string name);
        push(3, nf, nc);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        drain({name, "_drain"});
        chk({name, "_front"}, int'(front_bank), nf);
        chk({name, "_count"}, int'(frame_count), nc);
        chk({name, "_wr_bank"}, int'(wr_bank), 1 - nf);
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_sot = 1'b0; rx_eot = 1'b1; vblank = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_front", int'(front_bank), 0);
        chk("rst_wr_bank", int'(wr_bank), 1);
        chk("rst_flip", int'(flip), 0);
        chk("rst_err", int'({err_short, err_long}), 0);
        chk("rst_count", int'(frame_count), 0);
        rst_n = 1'b1;
        tick();

        // 1: full frame, flip held off until vblank
        frame_body(FRAME_BYTES, 1);
        end_frame(1'b0);
        repeat (10) tick();
        drain("t1_writes");
        chk("t1_front_hold", int'(front_bank), 0);
        do_flip(1, 1, "t1_flip");

        // 2: short frame, then a stray non-sot byte in IDLE
        frame_body(100, 0);
        end_frame(1'b1);
        drain("t2_drain");
        chk("t2_front", int'(front_bank), 1);
        chk("t2_count", int'(frame_count), 1);
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
        drain("t2_idle_ignore");

        // 3: overlong frame
        frame_body(FRAME_BYTES + 4, 0);
        end_frame(1'b0);
        drain("t3_drain");
        do_flip(0, 2, "t3_flip");

        // 4: bytes during WAIT_FLIP are dropped
        frame_body(FRAME_BYTES, 1);
        end_frame(1'b0);
        rx_eot = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1; rx_sot = (i == 0); rx_data = 8'(8'hA0 + i);
            tick();
            rx_valid = 1'b0; rx_sot = 1'b0;
            tick();
        end
        rx_eot = 1'b1;
        repeat (5) tick();
        drain("t4_no_write");
        do_flip(1, 3, "t4_flip");
        frame_body(FRAME_BYTES, 0);
        end_frame(1'b0);
        do_flip(0, 4, "t4_flip2");

        // 5: back-to-back frames with vblank held high
        vblank = 1'b1;
        frame_body(FRAME_BYTES, 1);
        push(3, 1, 5);
        end_frame(1'b0);
        drain("t5_a");
        frame_body(FRAME_BYTES, 0);
        push(3, 0, 6);
        end_frame(1'b0);
        drain("t5_b");
        vblank = 1'b0;
        chk("t5_front", int'(front_bank), 0);
        chk("t5_count", int'(frame_count), 6);
        frame_body(FRAME_BYTES, 1);
        end_frame(1'b0);
        do_flip(1, 7, "t5_flip3");

        // 6: async reset mid-frame while a write strobe is high
        frame_body(699, 0);
        rx_valid = 1'b1; rx_data = 8'hBB;
        tick();
        rx_valid = 1'b0;
        chk("t6_wr_en_pre", int'(wr_en), 1);
        chk("t6_q_pre", q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wr_en", int'(wr_en), 0);
        chk("t6_wr_addr", int'(wr_addr), 0);
        chk("t6_wr_data", int'(wr_data), 0);
        chk("t6_front", int'(front_bank), 0);
        chk("t6_count", int'(frame_count), 0);
        chk("t6_wr_bank", int'(wr_bank), 1);
        tick();
        rx_eot = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        frame_body(FRAME_BYTES, 1);
        end_frame(1'b0);
        do_flip(1, 1, "t6_flip");

        drain("final_drain");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
